// File: rtl/ram_arbiter.sv
// ram_arbiter: two-client round-robin arbiter and access sequencer for a
// single-port RAM with a shared bidirectional data bus. Each transaction runs
// IDLE -> ACCESS -> RESP, and the granted client gets a one-cycle ack in RESP.
module ram_arbiter #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          wr0,
    input  logic          wr1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic [AW-1:0] ram_adder,
    output logic          ram_we,
    inout  wire  [DW-1:0] ram_data
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic          last;       // id of the most recently granted client
    logic          cur_id;     // id of the client owning the current transaction
    logic          cur_wr;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wdata;
    logic          grant;
    logic          grant_id;

    // Round-robin pick: on a tie the client that was not granted last wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path leaves it unassigned and no latch is inferred.
        grant    = req0 | req1;
        grant_id = 1'b0;
        if (req0 && req1) begin
            grant_id = ~last;
        end else if (req1) begin
            grant_id = 1'b1;
        end
    end

    // Next-state decode; requests are only looked at in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (grant) state_next = ST_ACCESS;
            ST_ACCESS: state_next = ST_RESP;
            ST_RESP:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of block ordering.
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the winner's command and remember it for the next tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last      <= 1'b1;
            cur_id    <= 1'b0;
            cur_wr    <= 1'b0;
            cur_addr  <= '0;
            cur_wdata <= '0;
        end else if (state == ST_IDLE && grant) begin
            last      <= grant_id;
            cur_id    <= grant_id;
            cur_wr    <= grant_id ? wr1 : wr0;
            cur_addr  <= grant_id ? addr1 : addr0;
            cur_wdata <= grant_id ? wdata1 : wdata0;
        end
    end

    // Capture the RAM's read data at the closing edge of a read ACCESS cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (state == ST_ACCESS && !cur_wr) begin
            rdata <= ram_data;
        end
    end

    // Bus drive and write enable come from one term, so the RAM and this block
    // can never drive the data bus in the same cycle. Both are decoded from the
    // state register, so an asynchronous reset releases the bus at once.
    assign ram_we    = (state == ST_ACCESS) && cur_wr;
    assign ram_data  = ram_we ? cur_wdata : {DW{1'bz}};
    assign ram_adder = cur_addr;

    assign busy = (state != ST_IDLE);
    assign ack0 = (state == ST_RESP) && !cur_id;
    assign ack1 = (state == ST_RESP) &&  cur_id;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: a behavioural 16x8 RAM sits on the shared bus,
// client drivers issue commands, a reference model predicts completion order
// and data, and a monitor checks every ack and every bus cycle against it.
module tb_ram_arbiter;

    typedef struct packed {
        logic       wr;
        logic [3:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic       client;
        logic       wr;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic       wr0 = 1'b0, wr1 = 1'b0;
    logic [3:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic       ack0, ack1, busy, ram_we;
    logic [7:0] rdata;
    logic [3:0] ram_adder;
    wire  [7:0] ram_data;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // RAM: drives the bus whenever it is not being written.
    logic [7:0] mem [16] = '{default: 8'h00};
    assign ram_data = ram_we ? 8'hzz : mem[ram_adder];
    always @(posedge clk) begin
        if (ram_we) mem[ram_adder] <= ram_data;
    end

    // Reference model state.
    logic [7:0] model_mem [16] = '{default: 8'h00};
    logic       model_last = 1'b1;
    logic [7:0] model_rdata = 8'h00;
    exp_t       exp_q[$];

    ram_arbiter #(.AW(4), .DW(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
        .ram_adder(ram_adder), .ram_we(ram_we), .ram_data(ram_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a completed transaction updates memory, the read register and
    // the round-robin history, and its expected result is queued.
    task automatic push_exp(input logic client, input cmd_t c);
        exp_t e;
        e.client = client;
        e.wr     = c.wr;
        e.addr   = c.addr;
        e.wdata  = c.wdata;
        if (c.wr) begin
            model_mem[c.addr] = c.wdata;
        end else begin
            model_rdata = model_mem[c.addr];
        end
        e.rdata    = model_rdata;
        model_last = client;
        exp_q.push_back(e);
    endtask

    // One client: present command after 'late' cycles, wait for n acks.
    task automatic drive_client(input logic id, input cmd_t c, input int late,
                                input int n, input int off, input int start);
        bit seen;
        repeat (late) @(negedge clk);
        if (!id) begin
            wr0 = c.wr; addr0 = c.addr; wdata0 = c.wdata; req0 = 1'b1;
        end else begin
            wr1 = c.wr; addr1 = c.addr; wdata1 = c.wdata; req1 = 1'b1;
        end
        for (int t = 0; t < n; t++) begin
            seen = 1'b0;
            for (int k = 0; k < 16 && !seen; k++) begin
                @(negedge clk);
                if ((id ? ack1 : ack0) === 1'b1) seen = 1'b1;
            end
            if (!seen) check(id ? "ack1_timeout" : "ack0_timeout", 32'(seen), 32'd1);
            else       check(id ? "ack1_latency" : "ack0_latency", 32'(cyc - start), 32'(off + 3 * t));
        end
        if (!id) req0 = 1'b0; else req1 = 1'b0;
    endtask

    // One round: the participating clients present commands together (client
    // 0 optionally late); completion order follows the round-robin rule, and
    // each grant takes three cycles with ack in the third.
    task automatic do_round(input bit en0, input cmd_t c0, input bit en1, input cmd_t c1,
                            input int late0, input bit hold);
        int seq[$];
        int off0, off1, start, n;
        off0 = 0; off1 = 0;
        n = hold ? 2 : 1;
        @(negedge clk);
        start = cyc;
        if (en0 && en1) begin
            if (late0 > 0 || model_last == 1'b0) seq = '{1, 0};
            else                                 seq = '{0, 1};
        end else if (en0) begin
            seq = hold ? '{0, 0} : '{0};
        end else begin
            seq = hold ? '{1, 1} : '{1};
        end
        for (int p = seq.size() - 1; p >= 0; p--) begin
            if (seq[p] == 0) off0 = 2 + 3 * p; else off1 = 2 + 3 * p;
        end
        foreach (seq[p]) begin
            if (seq[p] == 0) push_exp(1'b0, c0); else push_exp(1'b1, c1);
        end
        fork
            begin if (en0) drive_client(1'b0, c0, late0, n, off0, start); end
            begin if (en1) drive_client(1'b1, c1, 0, n, off1, start); end
        join
    endtask

    function automatic cmd_t mk(input logic wr, input logic [3:0] a, input logic [7:0] d);
        cmd_t c;
        c.wr = wr; c.addr = a; c.wdata = d;
        return c;
    endfunction

    function automatic cmd_t rnd_cmd();
        cmd_t c;
        c.wr    = 1'($urandom_range(0, 1));
        c.addr  = 4'($urandom_range(0, 15));
        c.wdata = 8'($urandom);
        return c;
    endfunction

    // Monitor: bus ownership every cycle, write cycles, and each ack.
    initial begin
        int   we_cnt;
        logic prev_ack;
        exp_t e;
        we_cnt = 0;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                we_cnt = 0;
                prev_ack = 1'b0;
            end else begin
                if (!ram_we) begin
                    check("bus_owned_by_ram", 32'(ram_data), 32'(mem[ram_adder]));
                end else begin
                    we_cnt++;
                    if (exp_q.size() == 0) begin
                        check("we_without_txn", 32'(ram_we), 32'd0);
                    end else begin
                        check("we_on_read", 32'(ram_we & ~exp_q[0].wr), 32'd0);
                        check("we_addr", 32'(ram_adder), 32'(exp_q[0].addr));
                        check("we_data", 32'(ram_data), 32'(exp_q[0].wdata));
                    end
                end
                check("ack_onehot", 32'(ack0 & ack1), 32'd0);
                if (ack0 || ack1) begin
                    check("busy_in_ack", 32'(busy), 32'd1);
                    check("ack_pulse", 32'(prev_ack), 32'd0);
                    if (exp_q.size() == 0) begin
                        check("ack_without_txn", 32'(ack0 | ack1), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("ack_client", 32'(ack1), 32'(e.client));
                        check("rdata", 32'(rdata), 32'(e.rdata));
                        check("we_cycles", 32'(we_cnt), 32'(e.wr));
                    end
                    we_cnt = 0;
                end
                prev_ack = ack0 | ack1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        bit   seen;
        bit   en0, en1, hold;
        int   late0, r;
        cmd_t none;
        none = mk(1'b0, 4'd0, 8'd0);

        // Reset state with both requests low.
        repeat (3) @(negedge clk);
        check("rst_ack0", 32'(ack0), 32'd0);
        check("rst_ack1", 32'(ack1), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_adder", 32'(ram_adder), 32'd0);
        check("rst_we", 32'(ram_we), 32'd0);
        check("rst_bus_released", 32'(ram_data), 32'(mem[ram_adder]));
        rst = 1'b0;

        // Both clients requesting from reset: client 0 wins the first tie.
        do_round(1, mk(1'b1, 4'd0, 8'h11), 1, mk(1'b1, 4'd15, 8'h22), 0, 0);
        do_round(1, mk(1'b0, 4'd0, 8'h00), 1, mk(1'b0, 4'd15, 8'h00), 0, 0);

        // Client 0 writes then reads back address 3.
        do_round(1, mk(1'b1, 4'd3, 8'hA5), 0, none, 0, 0);
        do_round(1, mk(1'b0, 4'd3, 8'h00), 0, none, 0, 0);

        // Client 1 reads 7 first, client 0 arrives during ACCESS, then RESP.
        do_round(1, mk(1'b1, 4'd7, 8'h3C), 1, mk(1'b0, 4'd7, 8'h00), 1, 0);
        do_round(1, mk(1'b0, 4'd7, 8'h00), 1, mk(1'b0, 4'd3, 8'h00), 2, 0);

        // Request held through ack: the same command runs twice.
        do_round(0, none, 1, mk(1'b1, 4'd5, 8'h77), 0, 1);
        do_round(1, mk(1'b0, 4'd5, 8'h00), 0, none, 0, 1);

        // Reset during the ACCESS cycle of a write to address 9.
        do_round(1, mk(1'b1, 4'd9, 8'h00), 0, none, 0, 0);
        @(negedge clk);
        wr0 = 1'b1; addr0 = 4'd9; wdata0 = 8'h5A; req0 = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (ram_we === 1'b1) seen = 1'b1;
        end
        check("abort_reached_access", 32'(seen), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_we_drops", 32'(ram_we), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_no_ack", 32'(ack0 | ack1), 32'd0);
        check("abort_bus_released", 32'(ram_data), 32'(mem[ram_adder]));
        req0 = 1'b0;
        @(negedge clk);
        check("abort_no_late_ack", 32'(ack0 | ack1), 32'd0);
        check("abort_rdata", 32'(rdata), 32'd0);
        rst = 1'b0;
        model_last  = 1'b1;
        model_rdata = 8'h00;
        do_round(1, mk(1'b0, 4'd9, 8'h00), 0, none, 0, 0);

        // Randomized rounds.
        for (int i = 0; i < 250; i++) begin
            r     = int'($urandom_range(0, 9));
            en0   = 1'($urandom_range(0, 1));
            en1   = 1'($urandom_range(0, 1));
            if (!en0 && !en1) en0 = 1'b1;
            late0 = (en0 && en1 && r < 3) ? int'($urandom_range(1, 2)) : 0;
            hold  = !(en0 && en1) && (r == 9);
            do_round(en0, rnd_cmd(), en1, rnd_cmd(), late0, hold);
        end

        repeat (4) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
